// File: rtl/temp_calc_multi.sv
// Multi-channel temperature calculator: sequential per-channel scan with a shared shift-add multiplier,
// per-frame maximum tracking and a hysteretic alarm. Optional IIR smoothing is enabled by AVG_FILTER_EN.
module temp_calc_multi #(
    parameter int CH_COUNT   = 4,
    parameter int SENSOR_W   = 4,
    parameter int COEF_W     = 4,
    parameter int BASE_W     = 5,
    parameter int FRAC_BITS  = 3,
    parameter int TEMP_W     = 8,
    parameter int ALARM_HYST = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [CH_COUNT*SENSOR_W-1:0]                   sensor_bus,
    input  logic [CH_COUNT*BASE_W-1:0]                     base_bus,
    input  logic [CH_COUNT*COEF_W-1:0]                     coef_bus,
    input  logic [TEMP_W-1:0]                              threshold,
    output logic                                           busy,
    output logic                                           temp_valid,
    output logic [((CH_COUNT > 1) ? $clog2(CH_COUNT) : 1)-1:0] temp_ch,
    output logic [TEMP_W-1:0]                              temperature,
    output logic                                           frame_done,
    output logic [TEMP_W-1:0]                              max_temp,
    output logic [((CH_COUNT > 1) ? $clog2(CH_COUNT) : 1)-1:0] max_ch,
    output logic                                           alarm,
    output logic                                           overflow
);
    localparam int CH_W   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int PROD_W = COEF_W + SENSOR_W;
    localparam int WIDE_W = (BASE_W > PROD_W) ? BASE_W : PROD_W;
    localparam int SUM_W  = ((WIDE_W > TEMP_W) ? WIDE_W : TEMP_W) + 1;
    localparam int CNT_W  = $clog2(COEF_W + 1);
    localparam logic [SUM_W-1:0]  SAT_MAX = SUM_W'((64'd1 << TEMP_W) - 64'd1);
    localparam logic [TEMP_W-1:0] HYST    = TEMP_W'(ALARM_HYST);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CH_COUNT - 1);
    localparam logic [CNT_W-1:0]  LAST_MUL = CNT_W'(COEF_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_EMIT, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [CH_COUNT*SENSOR_W-1:0] sensor_lat_q, sensor_lat_d;
    logic [CH_COUNT*BASE_W-1:0]   base_lat_q, base_lat_d;
    logic [CH_COUNT*COEF_W-1:0]   coef_lat_q, coef_lat_d;
    logic [TEMP_W-1:0]            thr_q, thr_d;
    logic [PROD_W-1:0]            mcand_q, mcand_d, acc_q, acc_d;
    logic [COEF_W-1:0]            mplier_q, mplier_d;
    logic [BASE_W-1:0]            base_sel_q, base_sel_d;
    logic [TEMP_W-1:0]            temp_q, temp_d, run_max_q, run_max_d, max_temp_q, max_temp_d;
    logic [CH_W-1:0]              temp_ch_q, temp_ch_d, run_max_ch_q, run_max_ch_d, max_ch_q, max_ch_d;
    logic                         alarm_q, alarm_d, overflow_q, overflow_d;

    logic [SUM_W-1:0]             sum;
    logic                         raw_sat;
    logic [TEMP_W-1:0]            raw_temp, emit_temp, hyst_floor;

`ifdef AVG_FILTER_EN
    logic [TEMP_W-1:0]            filt_q [CH_COUNT];
    logic [TEMP_W-1:0]            filt_d [CH_COUNT];
    logic                         seeded_q, seeded_d;
    logic [TEMP_W:0]              filt_sum;
`endif

    // Result path for the channel being emitted; sum carries one spare bit so saturation is detectable.
    always_comb begin
        sum      = SUM_W'(base_sel_q) + SUM_W'(acc_q >> FRAC_BITS);
        raw_sat  = (sum > SAT_MAX);
        raw_temp = raw_sat ? '1 : sum[TEMP_W-1:0];
`ifdef AVG_FILTER_EN
        filt_sum  = {1'b0, filt_q[ch_q]} + {1'b0, raw_temp} + 1'b1;
        emit_temp = seeded_q ? filt_sum[TEMP_W:1] : raw_temp;
`else
        emit_temp = raw_temp;
`endif
        hyst_floor = (thr_q > HYST) ? (thr_q - HYST) : '0;
    end

    // NOTE: every variable gets its hold value first, so no branch below can leave one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        cnt_d        = cnt_q;
        sensor_lat_d = sensor_lat_q;
        base_lat_d   = base_lat_q;
        coef_lat_d   = coef_lat_q;
        thr_d        = thr_q;
        mcand_d      = mcand_q;
        acc_d        = acc_q;
        mplier_d     = mplier_q;
        base_sel_d   = base_sel_q;
        temp_d       = temp_q;
        temp_ch_d    = temp_ch_q;
        run_max_d    = run_max_q;
        run_max_ch_d = run_max_ch_q;
        max_temp_d   = max_temp_q;
        max_ch_d     = max_ch_q;
        alarm_d      = alarm_q;
        overflow_d   = overflow_q;
`ifdef AVG_FILTER_EN
        filt_d       = filt_q;
        seeded_d     = seeded_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sensor_lat_d = sensor_bus;
                    base_lat_d   = base_bus;
                    coef_lat_d   = coef_bus;
                    thr_d        = threshold;
                    overflow_d   = 1'b0;
                    run_max_d    = '0;
                    run_max_ch_d = '0;
                    ch_d         = '0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                mcand_d    = PROD_W'(sensor_lat_q[ch_q*SENSOR_W +: SENSOR_W]);
                mplier_d   = coef_lat_q[ch_q*COEF_W +: COEF_W];
                base_sel_d = base_lat_q[ch_q*BASE_W +: BASE_W];
                acc_d      = '0;
                cnt_d      = '0;
                state_d    = S_MUL;
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_MUL) state_d = S_EMIT;
            end
            S_EMIT: begin
                temp_d    = emit_temp;
                temp_ch_d = ch_q;
                if (raw_sat) overflow_d = 1'b1;
`ifdef AVG_FILTER_EN
                filt_d[ch_q] = emit_temp;
`endif
                // Strictly greater, so on a tie the earlier (lower) channel stays recorded.
                if (emit_temp > run_max_q) begin
                    run_max_d    = emit_temp;
                    run_max_ch_d = ch_q;
                end
                if (ch_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                max_temp_d = run_max_q;
                max_ch_d   = run_max_ch_q;
                if (run_max_q >= thr_q)           alarm_d = 1'b1;
                else if (run_max_q < hyst_floor)  alarm_d = 1'b0;
`ifdef AVG_FILTER_EN
                seeded_d = 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            cnt_q        <= '0;
            sensor_lat_q <= '0;
            base_lat_q   <= '0;
            coef_lat_q   <= '0;
            thr_q        <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            base_sel_q   <= '0;
            temp_q       <= '0;
            temp_ch_q    <= '0;
            run_max_q    <= '0;
            run_max_ch_q <= '0;
            max_temp_q   <= '0;
            max_ch_q     <= '0;
            alarm_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            sensor_lat_q <= sensor_lat_d;
            base_lat_q   <= base_lat_d;
            coef_lat_q   <= coef_lat_d;
            thr_q        <= thr_d;
            mcand_q      <= mcand_d;
            acc_q        <= acc_d;
            mplier_q     <= mplier_d;
            base_sel_q   <= base_sel_d;
            temp_q       <= temp_d;
            temp_ch_q    <= temp_ch_d;
            run_max_q    <= run_max_d;
            run_max_ch_q <= run_max_ch_d;
            max_temp_q   <= max_temp_d;
            max_ch_q     <= max_ch_d;
            alarm_q      <= alarm_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef AVG_FILTER_EN
    // NOTE: the filter array is reset explicitly because the first-frame seed logic relies on a known state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_COUNT; i++) filt_q[i] <= '0;
            seeded_q <= 1'b0;
        end else begin
            filt_q   <= filt_d;
            seeded_q <= seeded_d;
        end
    end
`endif

    assign busy        = (state_q != S_IDLE);
    assign temp_valid  = (state_q == S_EMIT);
    assign frame_done  = (state_q == S_DONE);
    assign temperature = temp_valid ? emit_temp : temp_q;
    assign temp_ch     = temp_valid ? ch_q : temp_ch_q;
    assign max_temp    = frame_done ? run_max_q : max_temp_q;
    assign max_ch      = frame_done ? run_max_ch_q : max_ch_q;
    assign alarm       = alarm_q;
    assign overflow    = overflow_q;

endmodule
